// File: rtl/round_sat_pipe_if.sv
// Stream bundle for the round-and-saturate pipe: the wide input beat, the
// narrowed output beat with per-lane saturation flags, and the saturation
// event counter with its clear.
interface round_sat_pipe_if #(
    parameter int IN_W  = 14,
    parameter int OUT_W = 7,
    parameter int LANES = 4,
    parameter int CNT_W = 16
);
    logic                   in_valid;
    logic                   in_ready;
    logic [LANES*IN_W-1:0]  in_data;
    logic [1:0]             in_mode;
    logic                   out_valid;
    logic                   out_ready;
    logic [LANES*OUT_W-1:0] out_data;
    logic [LANES-1:0]       out_sat;
    logic [CNT_W-1:0]       sat_count;
    logic                   sat_clr;

    // Producer of input beats and consumer of output beats
    modport master (
        output in_valid, in_data, in_mode, out_ready, sat_clr,
        input  in_ready, out_valid, out_data, out_sat, sat_count
    );

    // The rounding unit itself
    modport slave (
        input  in_valid, in_data, in_mode, out_ready, sat_clr,
        output in_ready, out_valid, out_data, out_sat, sat_count
    );
endinterface

// File: rtl/round_sat_pipe.sv
// Multi-lane round-and-saturate pipe. Narrows signed IN_W words to signed
// OUT_W words after dropping SHIFT fraction bits with a per-beat rounding
// mode. Stage 1 holds the rounded values, stage 2 the saturated result that
// drives the output. A sticky counter tallies saturated lanes delivered.
module round_sat_pipe #(
    parameter int IN_W  = 14,
    parameter int OUT_W = 7,
    parameter int SHIFT = 6,
    parameter int LANES = 4,
    parameter int CNT_W = 16
) (
    input  logic            clk,
    input  logic            rst,
    round_sat_pipe_if.slave bus
);
    // One extra bit so adding the half-LSB can never wrap a positive word
    localparam int RW = IN_W + 1;
    localparam int PW = $clog2(LANES + 1);
    localparam int SW = CNT_W + PW;

    localparam logic signed [RW-1:0] HALF   = RW'(2 ** (SHIFT - 1));
    localparam logic signed [RW-1:0] SAT_HI = RW'(2 ** (OUT_W - 1) - 1);
    localparam logic signed [RW-1:0] SAT_LO = RW'(-(2 ** (OUT_W - 1)));
    localparam logic [OUT_W-1:0]     OUT_HI = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0]     OUT_LO = {1'b1, {(OUT_W-1){1'b0}}};
    localparam logic [SW-1:0]        CNT_MAX = {{PW{1'b0}}, {CNT_W{1'b1}}};

    logic signed [RW-1:0]   rnd_c [LANES];
    logic signed [RW-1:0]   s1_r  [LANES];
    logic                   s1_valid;
    logic                   s2_valid;
    logic [LANES*OUT_W-1:0] sat_data_c;
    logic [LANES-1:0]       sat_flag_c;
    logic [LANES*OUT_W-1:0] s2_data;
    logic [LANES-1:0]       s2_sat;
    logic [CNT_W-1:0]       cnt;
    logic [PW-1:0]          pop_c;
    logic [SW-1:0]          cnt_sum_c;
    logic                   s1_load;
    logic                   s2_load;
    logic                   xfer;

    // A stage refills when it is empty or its contents move on this cycle;
    // out_ready therefore reaches in_ready combinationally with no bubble.
    assign s2_load      = !s2_valid || bus.out_ready;
    assign s1_load      = !s1_valid || s2_load;
    assign xfer         = s2_valid && bus.out_ready;
    assign bus.in_ready = s1_load;

    assign bus.out_valid = s2_valid;
    assign bus.out_data  = s2_data;
    assign bus.out_sat   = s2_sat;
    assign bus.sat_count = cnt;

    // Round each lane of the incoming beat according to the beat's mode
    always_comb begin
        logic signed [IN_W-1:0] x;
        logic signed [RW-1:0]   xe;
        logic signed [RW-1:0]   trunc;
        logic signed [RW-1:0]   up;
        logic                   tie;
        x     = '0;
        xe    = '0;
        trunc = '0;
        up    = '0;
        tie   = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            x     = bus.in_data[i*IN_W +: IN_W];
            xe    = {x[IN_W-1], x};
            trunc = xe >>> SHIFT;
            up    = (xe + HALF) >>> SHIFT;
            tie   = (x[SHIFT-1:0] == HALF[SHIFT-1:0]);
            rnd_c[i] = up;
            case (bus.in_mode)
                2'd0:    rnd_c[i] = trunc;
                2'd1:    rnd_c[i] = up;
                2'd2:    rnd_c[i] = (tie && !x[SHIFT]) ? trunc : up;
                default: rnd_c[i] = (tie && x[IN_W-1]) ? trunc : up;
            endcase
        end
    end

    // Clamp the stage-1 values into the signed output range and flag clamps
    always_comb begin
        sat_data_c = '0;
        sat_flag_c = '0;
        for (int i = 0; i < LANES; i++) begin
            if (s1_r[i] > SAT_HI) begin
                sat_data_c[i*OUT_W +: OUT_W] = OUT_HI;
                sat_flag_c[i]                = 1'b1;
            end else if (s1_r[i] < SAT_LO) begin
                sat_data_c[i*OUT_W +: OUT_W] = OUT_LO;
                sat_flag_c[i]                = 1'b1;
            end else begin
                sat_data_c[i*OUT_W +: OUT_W] = s1_r[i][OUT_W-1:0];
            end
        end
    end

    // Count saturated lanes in the outgoing beat and form the widened sum
    always_comb begin
        pop_c = '0;
        for (int i = 0; i < LANES; i++) begin
            pop_c = pop_c + PW'(s2_sat[i]);
        end
        cnt_sum_c = SW'(cnt) + SW'(pop_c);
    end

    // Stage 1: capture rounded lanes whenever the stage may refill
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                s1_r[i] <= '0;
            end
        end else if (s1_load) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                for (int i = 0; i < LANES; i++) begin
                    s1_r[i] <= rnd_c[i];
                end
            end
        end
    end

    // Stage 2: capture saturated result; it holds while the consumer stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_data  <= '0;
            s2_sat   <= '0;
        end else if (s2_load) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_data <= sat_data_c;
                s2_sat  <= sat_flag_c;
            end
        end
    end

    // Sticky saturation counter: clear beats a same-cycle transfer, and the
    // count clamps at all-ones instead of wrapping
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (bus.sat_clr) begin
            cnt <= '0;
        end else if (xfer) begin
            cnt <= (cnt_sum_c > CNT_MAX) ? {CNT_W{1'b1}} : cnt_sum_c[CNT_W-1:0];
        end
    end
endmodule

// File: tb/tb_round_sat_pipe.sv
// Self-checking bench for round_sat_pipe: a reference model pushes expected
// beats into a queue on input acceptance and they are popped on output
// transfer. A second instance with a 3-bit counter exercises clamping.
module tb_round_sat_pipe;
    typedef struct packed {
        logic [27:0] data;
        logic [3:0]  sat;
    } beat_t;

    logic  clk;
    logic  rst;
    int    compared;
    int    mismatched;
    int    exp_cnt;
    beat_t sb[$];

    logic [13:0] tie_x   [3]  = '{14'h0060, 14'h00A0, 14'h3FA0};
    logic [6:0]  tie_exp [12] = '{7'h01, 7'h02, 7'h02, 7'h02,
                                  7'h02, 7'h03, 7'h02, 7'h03,
                                  7'h7E, 7'h7F, 7'h7E, 7'h7E};

    round_sat_pipe_if #(.IN_W(14), .OUT_W(7), .LANES(4), .CNT_W(16)) bus ();
    round_sat_pipe_if #(.IN_W(14), .OUT_W(7), .LANES(4), .CNT_W(3))  bus3 ();

    round_sat_pipe #(.IN_W(14), .OUT_W(7), .SHIFT(6), .LANES(4), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    round_sat_pipe #(.IN_W(14), .OUT_W(7), .SHIFT(6), .LANES(4), .CNT_W(3)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something wedges outside the bounded loops
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference for one lane: {sat, 7-bit result}
    function automatic logic [7:0] model_lane(input logic [13:0] x, input logic [1:0] m);
        int xi, q, f, r;
        logic [6:0] d;
        xi = int'($signed(x));
        q  = xi >>> 6;
        f  = xi & 63;
        case (m)
            2'd0:    r = q;
            2'd1:    r = (xi + 32) >>> 6;
            2'd2:    r = (f == 32 && (q & 1) == 0) ? q : ((xi + 32) >>> 6);
            default: r = (f == 32 && xi < 0) ? q : ((xi + 32) >>> 6);
        endcase
        if (r > 63)  return {1'b1, 7'h3F};
        if (r < -64) return {1'b1, 7'h40};
        d = r[6:0];
        return {1'b0, d};
    endfunction

    function automatic beat_t model_beat(input logic [55:0] d, input logic [1:0] m);
        beat_t b;
        logic [7:0] l;
        b = '0;
        for (int i = 0; i < 4; i++) begin
            l = model_lane(d[i*14 +: 14], m);
            b.data[i*7 +: 7] = l[6:0];
            b.sat[i]         = l[7];
        end
        return b;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        @(negedge clk);
        compared++;
        if (bus.out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        compared++;
        if (bus.out_data !== 28'h0) begin mismatched++; $display("[TB] FAIL reset_out_data: got %h want 0", bus.out_data); end
        compared++;
        if (bus.out_sat !== 4'h0) begin mismatched++; $display("[TB] FAIL reset_out_sat: got %b want 0", bus.out_sat); end
        compared++;
        if (bus.sat_count !== 16'h0) begin mismatched++; $display("[TB] FAIL reset_sat_count: got %0d want 0", bus.sat_count); end
        compared++;
        if (bus3.sat_count !== 3'h0) begin mismatched++; $display("[TB] FAIL reset_sat_count3: got %0d want 0", bus3.sat_count); end
        step();
        rst = 1'b0;
        @(negedge clk);
        compared++;
        if (bus.in_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_in_ready: got %b want 1", bus.in_ready); end
        step();
        exp_cnt = 0;
    endtask

    task automatic test_saturation();
        bus.in_data   = {14'h0000, 14'h3FFF, 14'h2000, 14'h1FFF};
        bus.in_mode   = 2'd1;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        compared++;
        if (bus.in_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL sat_accept: got %b want 1", bus.in_ready); end
        step();
        bus.in_valid = 1'b0;
        @(negedge clk);
        compared++;
        if (bus.out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL sat_latency_early: got %b want 0", bus.out_valid); end
        step();
        @(negedge clk);
        compared++;
        if (bus.out_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL sat_latency: got %b want 1", bus.out_valid); end
        compared++;
        if (bus.out_data !== {7'h00, 7'h00, 7'h40, 7'h3F}) begin mismatched++; $display("[TB] FAIL sat_data: got %h want %h", bus.out_data, {7'h00, 7'h00, 7'h40, 7'h3F}); end
        compared++;
        if (bus.out_sat !== 4'b0011) begin mismatched++; $display("[TB] FAIL sat_flags: got %b want 0011", bus.out_sat); end
        step();
        compared++;
        if (bus.sat_count !== 16'd2) begin mismatched++; $display("[TB] FAIL sat_count: got %0d want 2", bus.sat_count); end
        compared++;
        if (bus.out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL sat_drain: got %b want 0", bus.out_valid); end
        exp_cnt = 2;
    endtask

    task automatic test_modes();
        beat_t exp;
        int sent;
        sent = 0;
        bus.out_ready = 1'b1;
        for (int cyc = 0; cyc < 100 && (sent < 12 || sb.size() != 0); cyc++) begin
            bus.in_valid = (sent < 12);
            if (sent < 12) begin
                bus.in_data = {14'($urandom), 14'($urandom), 14'($urandom), tie_x[sent / 4]};
                bus.in_mode = 2'(sent % 4);
            end
            @(negedge clk);
            if (bus.out_valid && bus.out_ready) begin
                compared++;
                if (sb.size() == 0) begin
                    mismatched++; $display("[TB] FAIL modes_extra: got %h want none", bus.out_data);
                end else begin
                    exp = sb.pop_front();
                    exp_cnt += $countones(exp.sat);
                    if ({bus.out_data, bus.out_sat} !== {exp.data, exp.sat}) begin
                        mismatched++; $display("[TB] FAIL modes_beat: got %h/%b want %h/%b", bus.out_data, bus.out_sat, exp.data, exp.sat);
                    end
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                exp = model_beat(bus.in_data, bus.in_mode);
                exp.data[6:0] = tie_exp[sent];
                exp.sat[0]    = 1'b0;
                sb.push_back(exp);
                sent++;
            end
            step();
        end
        bus.in_valid = 1'b0;
        compared++;
        if (sent != 12 || sb.size() != 0) begin mismatched++; $display("[TB] FAIL modes_timeout: got %0d sent/%0d pending want 12/0", sent, sb.size()); end
        compared++;
        if (bus.sat_count !== 16'(exp_cnt)) begin mismatched++; $display("[TB] FAIL modes_count: got %0d want %0d", bus.sat_count, exp_cnt); end
    endtask

    task automatic test_back_to_back();
        beat_t exp;
        int sent, cycles, stalls;
        sent = 0; cycles = 0; stalls = 0;
        bus.out_ready = 1'b1;
        for (int cyc = 0; cyc < 200 && (sent < 32 || sb.size() != 0); cyc++) begin
            cycles++;
            bus.in_valid = (sent < 32);
            bus.in_data  = {$urandom, 24'($urandom)};
            bus.in_mode  = 2'($urandom_range(0, 3));
            @(negedge clk);
            if (bus.in_valid && !bus.in_ready) stalls++;
            if (bus.out_valid && bus.out_ready) begin
                compared++;
                if (sb.size() == 0) begin
                    mismatched++; $display("[TB] FAIL b2b_extra: got %h want none", bus.out_data);
                end else begin
                    exp = sb.pop_front();
                    exp_cnt += $countones(exp.sat);
                    if ({bus.out_data, bus.out_sat} !== {exp.data, exp.sat}) begin
                        mismatched++; $display("[TB] FAIL b2b_beat: got %h/%b want %h/%b", bus.out_data, bus.out_sat, exp.data, exp.sat);
                    end
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                sb.push_back(model_beat(bus.in_data, bus.in_mode));
                sent++;
            end
            step();
        end
        bus.in_valid = 1'b0;
        compared++;
        if (sent != 32 || sb.size() != 0) begin mismatched++; $display("[TB] FAIL b2b_timeout: got %0d sent/%0d pending want 32/0", sent, sb.size()); end
        compared++;
        if (stalls != 0) begin mismatched++; $display("[TB] FAIL b2b_stalls: got %0d want 0", stalls); end
        compared++;
        if (cycles != 34) begin mismatched++; $display("[TB] FAIL b2b_cycles: got %0d want 34", cycles); end
        compared++;
        if (bus.sat_count !== 16'(exp_cnt)) begin mismatched++; $display("[TB] FAIL b2b_count: got %0d want %0d", bus.sat_count, exp_cnt); end
    endtask

    task automatic test_backpressure();
        beat_t exp;
        int sent;
        sent = 0;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        for (int cyc = 0; cyc < 6; cyc++) begin
            bus.in_data = {$urandom, 24'($urandom)};
            bus.in_mode = 2'($urandom_range(0, 3));
            @(negedge clk);
            if (bus.out_valid && sb.size() != 0) begin
                compared++;
                if ({bus.out_data, bus.out_sat} !== {sb[0].data, sb[0].sat}) begin
                    mismatched++; $display("[TB] FAIL bp_hold: got %h/%b want %h/%b", bus.out_data, bus.out_sat, sb[0].data, sb[0].sat);
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                sb.push_back(model_beat(bus.in_data, bus.in_mode));
                sent++;
            end
            step();
        end
        compared++;
        if (sent != 2) begin mismatched++; $display("[TB] FAIL bp_accepts: got %0d want 2", sent); end
        compared++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL bp_full: got ready=%b valid=%b want 0/1", bus.in_ready, bus.out_valid); end
        bus.out_ready = 1'b1;
        for (int cyc = 0; cyc < 50 && (sent < 5 || sb.size() != 0); cyc++) begin
            bus.in_valid = (sent < 5);
            bus.in_data  = {$urandom, 24'($urandom)};
            bus.in_mode  = 2'($urandom_range(0, 3));
            @(negedge clk);
            if (cyc == 0) begin
                compared++;
                if (bus.in_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL bp_release: got %b want 1", bus.in_ready); end
            end
            if (bus.out_valid && bus.out_ready) begin
                compared++;
                if (sb.size() == 0) begin
                    mismatched++; $display("[TB] FAIL bp_extra: got %h want none", bus.out_data);
                end else begin
                    exp = sb.pop_front();
                    exp_cnt += $countones(exp.sat);
                    if ({bus.out_data, bus.out_sat} !== {exp.data, exp.sat}) begin
                        mismatched++; $display("[TB] FAIL bp_beat: got %h/%b want %h/%b", bus.out_data, bus.out_sat, exp.data, exp.sat);
                    end
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                sb.push_back(model_beat(bus.in_data, bus.in_mode));
                sent++;
            end
            step();
        end
        bus.in_valid = 1'b0;
        compared++;
        if (sent != 5 || sb.size() != 0) begin mismatched++; $display("[TB] FAIL bp_timeout: got %0d sent/%0d pending want 5/0", sent, sb.size()); end
        compared++;
        if (bus.sat_count !== 16'(exp_cnt)) begin mismatched++; $display("[TB] FAIL bp_count: got %0d want %0d", bus.sat_count, exp_cnt); end
    endtask

    task automatic test_random_stream(input int n);
        beat_t exp;
        int sent;
        sent = 0;
        for (int cyc = 0; cyc < 20 * n && (sent < n || sb.size() != 0); cyc++) begin
            bus.in_valid  = (sent < n) && ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.in_data   = {$urandom, 24'($urandom)};
            bus.in_mode   = 2'($urandom_range(0, 3));
            @(negedge clk);
            if (bus.out_valid && bus.out_ready) begin
                compared++;
                if (sb.size() == 0) begin
                    mismatched++; $display("[TB] FAIL rand_extra: got %h want none", bus.out_data);
                end else begin
                    exp = sb.pop_front();
                    exp_cnt += $countones(exp.sat);
                    if ({bus.out_data, bus.out_sat} !== {exp.data, exp.sat}) begin
                        mismatched++; $display("[TB] FAIL rand_beat: got %h/%b want %h/%b", bus.out_data, bus.out_sat, exp.data, exp.sat);
                    end
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                sb.push_back(model_beat(bus.in_data, bus.in_mode));
                sent++;
            end
            step();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        compared++;
        if (sent != n || sb.size() != 0) begin mismatched++; $display("[TB] FAIL rand_timeout: got %0d sent/%0d pending want %0d/0", sent, sb.size(), n); end
        compared++;
        if (bus.sat_count !== 16'(exp_cnt)) begin mismatched++; $display("[TB] FAIL rand_count: got %0d want %0d", bus.sat_count, exp_cnt); end
    endtask

    task automatic test_counter_clamp();
        int sent, xfers, exp3;
        sent = 0; xfers = 0; exp3 = 0;
        bus3.out_ready = 1'b1;
        bus3.in_mode   = 2'd0;
        bus3.in_data   = {4{14'h1FFF}};
        for (int cyc = 0; cyc < 8; cyc++) begin
            bus3.in_valid = (sent < 3);
            @(negedge clk);
            if (bus3.out_valid && bus3.out_ready) begin
                xfers++;
                exp3 = (exp3 + 4 > 7) ? 7 : exp3 + 4;
            end
            if (bus3.in_valid && bus3.in_ready) sent++;
            step();
            compared++;
            if (bus3.sat_count !== 3'(exp3)) begin mismatched++; $display("[TB] FAIL clamp_step: got %0d want %0d", bus3.sat_count, exp3); end
        end
        compared++;
        if (xfers != 3 || bus3.sat_count !== 3'd7) begin mismatched++; $display("[TB] FAIL clamp_final: got %0d xfers count %0d want 3 / 7", xfers, bus3.sat_count); end
        bus3.in_valid = 1'b1;
        step();
        bus3.in_valid = 1'b0;
        for (int k = 0; k < 8 && !bus3.out_valid; k++) step();
        bus3.sat_clr = 1'b1;
        @(negedge clk);
        compared++;
        if (bus3.out_valid !== 1'b1 || bus3.out_sat !== 4'hF) begin mismatched++; $display("[TB] FAIL clr_beat: got valid=%b sat=%b want 1/1111", bus3.out_valid, bus3.out_sat); end
        step();
        bus3.sat_clr = 1'b0;
        compared++;
        if (bus3.sat_count !== 3'd0) begin mismatched++; $display("[TB] FAIL clr_wins: got %0d want 0", bus3.sat_count); end
    endtask

    task automatic test_reset_midstream();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_mode   = 2'd0;
        bus.in_data   = {4{14'h1FFF}};
        step();
        step();
        bus.in_valid = 1'b0;
        @(negedge clk);
        compared++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL mid_full: got ready=%b valid=%b want 0/1", bus.in_ready, bus.out_valid); end
        compared++;
        if (bus.sat_count !== 16'(exp_cnt)) begin mismatched++; $display("[TB] FAIL mid_precount: got %0d want %0d", bus.sat_count, exp_cnt); end
        rst = 1'b1;
        bus.out_ready = 1'b1;
        step();
        rst = 1'b0;
        exp_cnt = 0;
        @(negedge clk);
        compared++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL mid_reset: got valid=%b ready=%b want 0/1", bus.out_valid, bus.in_ready); end
        compared++;
        if (bus.sat_count !== 16'd0 || bus.out_sat !== 4'h0) begin mismatched++; $display("[TB] FAIL mid_clear: got count=%0d sat=%b want 0/0", bus.sat_count, bus.out_sat); end
        for (int k = 0; k < 6; k++) begin
            step();
            @(negedge clk);
            compared++;
            if (bus.out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL mid_stale: got %b want 0 at cycle %0d", bus.out_valid, k); end
        end
        step();
    endtask

    // Test sequence
    initial begin
        compared       = 0;
        mismatched     = 0;
        exp_cnt        = 0;
        rst            = 1'b1;
        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        bus.in_mode    = 2'd0;
        bus.out_ready  = 1'b0;
        bus.sat_clr    = 1'b0;
        bus3.in_valid  = 1'b0;
        bus3.in_data   = '0;
        bus3.in_mode   = 2'd0;
        bus3.out_ready = 1'b0;
        bus3.sat_clr   = 1'b0;
        test_reset();
        test_saturation();
        test_modes();
        test_back_to_back();
        test_backpressure();
        test_random_stream(60);
        test_counter_clamp();
        test_reset_midstream();
        test_random_stream(40);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/round_sat_pipe.md
# round_sat_pipe

Pipelined, multi-lane round-and-saturate unit that narrows signed fixed-point accumulator or product words to the PE data width. It is the parametrised successor to the fixed 14-to-7-bit rounding unit. It adds selectable rounding modes, LANES parallel channels, a valid/ready handshake with back-pressure, per-lane saturation flags and a sticky saturation event counter. It sits between the systolic array output drain and the result write-back path.

## Interface
Parameters:
- IN_W, 14, signed input word width per lane
- OUT_W, 7, signed output word width per lane
- SHIFT, 6, LSBs dropped by rounding (binary-point shift); 1 ≤ SHIFT < IN_W
- LANES, 4, parallel channels
- CNT_W, 16, saturation counter width

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  unit accepts beat this cycle
- in_data  in  LANES*IN_W  lane i at bits [i*IN_W +: IN_W]
- in_mode  in  2  rounding mode, sampled with the beat: 0 truncate (floor), 1 half-up, 2 half-even, 3 half-away-from-zero
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts
- out_data  out  LANES*OUT_W  lane i at bits [i*OUT_W +: OUT_W]
- out_sat  out  LANES  lane i saturated in this beat
- sat_count  out  CNT_W  saturated-lane events delivered since reset or clear
- sat_clr  in  1  synchronous clear of sat_count

## Operation
- Per lane, x is signed IN_W, f = x[SHIFT-1:0], and h = 2^(SHIFT-1).
- Intermediate width is IN_W+1 so that the round increment cannot wrap.
- Mode 0: r = x >>> SHIFT (arithmetic).
- Mode 1: r = (x + h) >>> SHIFT.
- Mode 2: same as mode 1, except when f == h and bit x[SHIFT] == 0, then r = x >>> SHIFT.
- Mode 3: same as mode 1, except when x < 0 and f == h, then r = x >>> SHIFT.
- Saturation:
  - r > 2^(OUT_W-1)-1 → out = 2^(OUT_W-1)-1 and out_sat[i] = 1.
  - r < -2^(OUT_W-1) → out = -2^(OUT_W-1) and out_sat[i] = 1.
  - Otherwise out = r[OUT_W-1:0] and out_sat[i] = 0.
- Pipeline, two register stages:
  - S1 holds the rounded intermediate values plus a valid bit.
  - S2 holds the saturated data, the flags and a valid bit; S2 drives out_*.
- A stage loads when it is empty or when its contents move forward this cycle.
- in_ready = !s1_valid || !s2_valid || out_ready. The out_ready → in_ready path is combinational; no bubbles are inserted.
- Output handshake: a beat transfers on out_valid && out_ready. out_data and out_sat hold stable while out_valid && !out_ready.
- sat_count:
  - On each output transfer it adds popcount(out_sat).
  - It clamps at 2^CNT_W-1 and never wraps.
  - When sat_clr and a transfer occur in the same cycle, clear wins and the result is 0.
- in_mode is captured per beat. A mode change between beats affects only later beats.

## Timing
- Reset: out_valid=0, out_data=0, out_sat=0, sat_count=0, and both stage valids are 0.
- in_ready=1 in the first cycle after reset.
- Reset asserted mid-stream discards all in-flight beats with no partial output.
- Latency: a beat accepted at edge N appears with out_valid=1 after edge N+2 when out_ready stays high.
- Throughput: one beat per cycle.
- Stall: with out_ready=0, at most two beats are buffered (S1 and S2), then in_ready=0.
- When out_ready rises, in_ready rises in the same cycle.
- Empty pipeline with in_valid=0: out_valid drops after the last beat transfers.
- No combinational path from in_data to out_data.

## Test plan
Defaults throughout: IN_W=14, SHIFT=6, OUT_W=7.
- Rounding modes on lane 0 = 14'h0060 (+1.5):
  - Modes 0/1/2/3 → 7'h01 / 7'h02 / 7'h02 / 7'h02, out_sat=0.
- Ties on 14'h00A0 (+2.5) and 14'h3FA0 (-1.5):
  - +2.5, modes 0..3 → 02, 03, 02, 03.
  - -1.5, modes 0..3 → 7E, 7F, 7E, 7E.
- Saturation and counter:
  - Lanes {14'h1FFF, 14'h2000, 14'h3FFF, 14'h0000} in mode 1 → {7'h3F, 7'h40, 7'h00, 7'h00}, out_sat=4'b0011, sat_count=2 after the transfer.
- Back-pressure:
  - Stream 5 beats with out_ready=0 → in_ready drops after 2 accepts.
  - Raise out_ready → all 5 beats emerge in order, none lost or duplicated, output stable while stalled.
- Counter boundary:
  - With CNT_W=3, drive 3 beats of 4 saturated lanes → sat_count clamps at 7.
  - sat_clr coincident with a saturated transfer → 0.
- Reset mid-stream:
  - Assert rst with both stages full → next cycle out_valid=0, sat_count=0, in_ready=1, and no stale beat appears afterwards.
